rv_test_monitor: RTL and testbench

Synthesizable end-of-test monitor for the rvlife RISC-V cores. Snoops the register-file write-back port, keeps shadow copies of the done, pass and test-number registers, and drives sticky pass/fail/timeout status plus an optional cycle and retire counter. Sits beside the core's write-back stage in both the single-cycle and later pipelined tops, so benches and FPGA builds share one completion mechanism.

---
 rtl/rv_test_monitor_pkg.sv | 22 ++
 rtl/rv_test_monitor_if.sv | 16 +
 rtl/rv_test_monitor_satcnt.sv | 37 +++
 rtl/rv_test_monitor.sv | 126 ++++++++++++
 tb/tb_rv_test_monitor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_test_monitor_pkg.sv
// Shared types and constants for the rvlife end-of-test monitor.
// Holds the monitor state encoding and the RISC-V ABI register indices it snoops.
`timescale 1ns/1ps
package rv_mon_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } mon_state_e;

    localparam int unsigned REG_GP  = 3;
    localparam int unsigned REG_S10 = 26;
    localparam int unsigned REG_S11 = 27;

    function automatic logic is_terminal(input mon_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
    endfunction

endpackage

// File: rtl/rv_test_monitor_if.sv
// Register-file write-back port plus retire pulse, as seen by the test monitor.
// The core drives the master side; the monitor only listens on the slave side.
`timescale 1ns/1ps
interface rv_mon_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            retire;

    modport master (output wb_en, wb_addr, wb_data, retire);
    modport slave  (input  wb_en, wb_addr, wb_data, retire);

endinterface

// File: rtl/rv_test_monitor_satcnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Used for the watchdog and for the optional cycle/retire counters.
`timescale 1ns/1ps
module rv_mon_satcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats enable; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_test_monitor.sv
// End-of-test monitor: snoops write-back, shadows done/pass/test-number registers, reports sticky status.
// Optional cycle/retire counters are built only when RV_MON_PERF_EN is defined.
`timescale 1ns/1ps
module rv_test_monitor
    import rv_mon_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DONE_REG = REG_S10,
    parameter int unsigned PASS_REG = REG_S11,
    parameter int unsigned TNUM_REG = REG_GP,
    parameter int unsigned TMO_W    = 16,
    parameter int unsigned TMO_CYC  = 5000
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    rv_mon_if.slave         wb,
    output logic            mon_done_o,
    output logic            mon_pass_o,
    output logic            mon_fail_o,
    output logic            mon_timeout_o,
    output logic [XLEN-1:0] fail_tnum_o,
    output logic [31:0]     cycle_cnt_o,
    output logic [31:0]     retire_cnt_o
);

    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TMO_CYC - 1);

    mon_state_e      state_q, state_d;
    logic [XLEN-1:0] passSh_q, tnumSh_q, failTnum_q, failTnum_d;
    logic            done_q, pass_q, fail_q, tmo_q;
    logic [TMO_W-1:0] wdogCnt;
    logic            wbValid, doneDet, passWr, tnumWr, inRun, inActive;
    logic [XLEN-1:0] effPass, effTnum;

    // x0 writes never reach the shadows or the done detector, whatever the index parameters say.
    always_comb begin
        wbValid  = wb.wb_en && (wb.wb_addr != 5'd0);
        doneDet  = wbValid && (wb.wb_addr == 5'(DONE_REG)) && (wb.wb_data == XLEN'(1));
        passWr   = wbValid && (wb.wb_addr == 5'(PASS_REG));
        tnumWr   = wbValid && (wb.wb_addr == 5'(TNUM_REG));
        effPass  = passWr ? wb.wb_data : passSh_q;
        effTnum  = tnumWr ? wb.wb_data : tnumSh_q;
        inRun    = (state_q == ST_RUN);
        inActive = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    end

    // Done outranks the watchdog; SETTLE waits one cycle so a late pass/tnum write still counts.
    always_comb begin
        state_d    = state_q;
        failTnum_d = failTnum_q;
        case (state_q)
            ST_RUN: begin
                if (doneDet) begin
                    state_d = ST_SETTLE;
                end else if (wdogCnt == WDOG_LAST) begin
                    state_d = ST_TMO;
                end
            end
            ST_SETTLE: state_d = (effPass == XLEN'(1)) ? ST_PASS : ST_FAIL;
            default:   state_d = state_q;
        endcase
        if (is_terminal(state_d) && !is_terminal(state_q)) begin
            failTnum_d = effTnum;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_RUN;
            passSh_q   <= '0;
            tnumSh_q   <= '0;
            failTnum_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            failTnum_q <= failTnum_d;
            if (passWr) passSh_q <= wb.wb_data;
            if (tnumWr) tnumSh_q <= wb.wb_data;
            done_q     <= is_terminal(state_d);
            pass_q     <= (state_d == ST_PASS);
            fail_q     <= (state_d == ST_FAIL);
            tmo_q      <= (state_d == ST_TMO);
        end
    end

    rv_mon_satcnt #(.W(TMO_W)) u_wdog (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (!inRun),
        .en_i   (inRun),
        .cnt_o  (wdogCnt)
    );

`ifdef RV_MON_PERF_EN
    rv_mon_satcnt #(.W(32)) u_cyc_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (1'b0),
        .en_i   (inActive),
        .cnt_o  (cycle_cnt_o)
    );

    rv_mon_satcnt #(.W(32)) u_ret_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (1'b0),
        .en_i   (inActive && wb.retire),
        .cnt_o  (retire_cnt_o)
    );
`else
    logic unused_perf;
    assign unused_perf  = inActive ^ wb.retire;
    assign cycle_cnt_o  = '0;
    assign retire_cnt_o = '0;
`endif

    assign mon_done_o    = done_q;
    assign mon_pass_o    = pass_q;
    assign mon_fail_o    = fail_q;
    assign mon_timeout_o = tmo_q;
    assign fail_tnum_o   = failTnum_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Bench for rv_test_monitor: directed table, corner sequences, and random traffic against a history-based model.
// A second instance with DONE_REG = 0 shows that x0 writes can never finish a test.
`timescale 1ns/1ps
module tb_rv_test_monitor;

    localparam int TMO_CYC_TB = 120;
    localparam int ALIAS_TMO  = 40;
`ifdef RV_MON_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        mDone, mPass, mFail, mTmo;
    logic [31:0] mTnum, mCyc, mRet;
    logic        aDone, aPass, aFail, aTmo;
    logic [31:0] aTnum, aCyc, aRet;

    rv_mon_if #(.XLEN(32)) wbIf ();

    always #5 clk = ~clk;

    rv_test_monitor #(.TMO_W(16), .TMO_CYC(TMO_CYC_TB)) dut (
        .clk_i(clk), .rstn_i(rstn), .wb(wbIf.slave),
        .mon_done_o(mDone), .mon_pass_o(mPass), .mon_fail_o(mFail), .mon_timeout_o(mTmo),
        .fail_tnum_o(mTnum), .cycle_cnt_o(mCyc), .retire_cnt_o(mRet)
    );

    rv_test_monitor #(.DONE_REG(0), .TMO_W(16), .TMO_CYC(ALIAS_TMO)) aliasDut (
        .clk_i(clk), .rstn_i(rstn), .wb(wbIf.slave),
        .mon_done_o(aDone), .mon_pass_o(aPass), .mon_fail_o(aFail), .mon_timeout_o(aTmo),
        .fail_tnum_o(aTnum), .cycle_cnt_o(aCyc), .retire_cnt_o(aRet)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ret;
    } cyc_t;

    typedef struct {
        logic        done, pass, fail, tmo;
        logic [31:0] tnum, cyc, ret;
    } exp_t;

    typedef struct {
        logic        rstFirst;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ret;
        logic        eDone, ePass, eFail, eTmo;
        logic [31:0] eTnum;
    } vec_t;

    cyc_t hist[$];
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;

    // Last value written to a register in cycles 0..upTo since reset, 0 if none.
    function automatic logic [31:0] lastWrite(input int regIdx, input int upTo);
        logic [31:0] v = '0;
        for (int c = 0; c <= upTo && c < hist.size(); c++) begin
            if (hist[c].en && hist[c].addr != 5'd0 && int'(hist[c].addr) == regIdx) v = hist[c].data;
        end
        return v;
    endfunction

    // Expected status after hist.size() edges: find the first qualifying done write before the
    // watchdog limit; the finish lands two edges later, otherwise the timeout lands at edge tmoCyc.
    function automatic exp_t refModel(input int doneReg, input int tmoCyc);
        exp_t e;
        int   k       = hist.size();
        int   doneAt  = -1;
        int   endEdge;
        int   lastCyc;
        int   n;
        e = '{default: '0};
        for (int c = 0; c < k && c < tmoCyc; c++) begin
            if (doneAt < 0 && hist[c].en && hist[c].addr != 5'd0 &&
                int'(hist[c].addr) == doneReg && hist[c].data == 32'd1) doneAt = c;
        end
        if (doneAt >= 0) begin
            endEdge = doneAt + 2;
            lastCyc = doneAt + 1;
        end else begin
            endEdge = tmoCyc;
            lastCyc = tmoCyc - 1;
        end
        if (k >= endEdge) begin
            e.done = 1'b1;
            e.tnum = lastWrite(3, lastCyc);
            if (doneAt >= 0) begin
                e.pass = (lastWrite(27, lastCyc) == 32'd1);
                e.fail = !e.pass;
            end else begin
                e.tmo = 1'b1;
            end
        end
        if (PERF_ON != 0) begin
            n = (k < endEdge) ? k : endEdge;
            e.cyc = 32'(n);
            for (int c = 0; c < n; c++) e.ret = e.ret + 32'(hist[c].ret);
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t em = refModel(26, TMO_CYC_TB);
        exp_t ea = refModel(0, ALIAS_TMO);
        cmp({tag, ".done"},     32'(mDone), 32'(em.done));
        cmp({tag, ".pass"},     32'(mPass), 32'(em.pass));
        cmp({tag, ".fail"},     32'(mFail), 32'(em.fail));
        cmp({tag, ".timeout"},  32'(mTmo),  32'(em.tmo));
        cmp({tag, ".tnum"},     mTnum,      em.tnum);
        cmp({tag, ".cycles"},   mCyc,       em.cyc);
        cmp({tag, ".retires"},  mRet,       em.ret);
        cmp({tag, ".aliasDone"}, 32'(aDone), 32'(ea.done));
        cmp({tag, ".aliasTmo"},  32'(aTmo),  32'(ea.tmo));
    endtask

    task automatic applyStimulus(input logic en, input logic [4:0] addr,
                                 input logic [31:0] data, input logic ret);
        cyc_t c;
        wbIf.wb_en   = en;
        wbIf.wb_addr = addr;
        wbIf.wb_data = data;
        wbIf.retire  = ret;
        c = '{en: en, addr: addr, data: data, ret: ret};
        hist.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        wbIf.wb_en   = 1'b0;
        wbIf.wb_addr = '0;
        wbIf.wb_data = '0;
        wbIf.retire  = 1'b0;
        rstn = 1'b0;
        hist.delete();
        @(posedge clk);
        #1;
        checkOutput("inReset");
        rstn = 1'b1;
    endtask

    task automatic idleTo(input int k);
        while (hist.size() < k) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [4:0]  rAddr;
        logic [31:0] rData;
        int          len;

        // Directed vectors: {reset?, en, addr, data, retire, done, pass, fail, timeout, tnum}
        vecs[0] = '{1'b1, 1'b1, 5'd27, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b0, 1'b1, 5'd3,  32'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 1'b1, 5'd26, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7};
        vecs[4] = '{1'b0, 1'b1, 5'd3,  32'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7};
        vecs[5] = '{1'b1, 1'b1, 5'd3,  32'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[6] = '{1'b0, 1'b1, 5'd27, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[7] = '{1'b0, 1'b1, 5'd26, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[8] = '{1'b0, 1'b0, 5'd0,  32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12};
        vecs[9] = '{1'b0, 1'b1, 5'd27, 32'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12};

        wbIf.wb_en = 1'b0; wbIf.wb_addr = '0; wbIf.wb_data = '0; wbIf.retire = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rstFirst) doReset();
            applyStimulus(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ret);
            cmp($sformatf("vec%0d.done", i),    32'(mDone), 32'(vecs[i].eDone));
            cmp($sformatf("vec%0d.pass", i),    32'(mPass), 32'(vecs[i].ePass));
            cmp($sformatf("vec%0d.fail", i),    32'(mFail), 32'(vecs[i].eFail));
            cmp($sformatf("vec%0d.timeout", i), 32'(mTmo),  32'(vecs[i].eTmo));
            cmp($sformatf("vec%0d.tnum", i),    mTnum,      vecs[i].eTnum);
            checkOutput($sformatf("vec%0d", i));
        end

        // Timeout: a non-1 done write is ignored, watchdog fires on edge TMO_CYC_TB.
        doReset();
        applyStimulus(1'b1, 5'd3, 32'd5, 1'b0);
        applyStimulus(1'b1, 5'd26, 32'd2, 1'b0);
        idleTo(TMO_CYC_TB - 1);
        cmp("tmo.beforeEdge", 32'(mTmo), 32'd0);
        checkOutput("tmo.pre");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        cmp("tmo.timeout", 32'(mTmo),  32'd1);
        cmp("tmo.done",    32'(mDone), 32'd1);
        cmp("tmo.pass",    32'(mPass), 32'd0);
        cmp("tmo.tnum",    mTnum,      32'd5);
        checkOutput("tmo.post");

        // Done on the last watchdog cycle wins; pass written during SETTLE is honoured.
        doReset();
        applyStimulus(1'b1, 5'd3, 32'd4, 1'b0);
        idleTo(TMO_CYC_TB - 1);
        applyStimulus(1'b1, 5'd26, 32'd1, 1'b0);
        cmp("race.timeout", 32'(mTmo),  32'd0);
        cmp("race.settle",  32'(mDone), 32'd0);
        applyStimulus(1'b1, 5'd27, 32'd1, 1'b0);
        cmp("race.pass",    32'(mPass), 32'd1);
        cmp("race.tmoLow",  32'(mTmo),  32'd0);
        cmp("race.tnum",    mTnum,      32'd4);
        checkOutput("race");

        // x0 writes of 1 never finish, even when DONE_REG is 0; then a mid-run reset restarts the watchdog.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd0, 32'd1, 1'b0);
        idleTo(8);
        cmp("x0.aliasDone", 32'(aDone), 32'd0);
        cmp("x0.mainDone",  32'(mDone), 32'd0);
        checkOutput("x0");
        doReset();
        idleTo(TMO_CYC_TB - 1);
        cmp("rst.noEarlyTmo", 32'(mTmo), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        cmp("rst.tmoOnTime",  32'(mTmo), 32'd1);
        checkOutput("rst");

        // Performance counters: 100 RUN cycles with 60 retires, then SETTLE, then frozen.
        doReset();
        for (int c = 0; c < 100; c++) begin
            if (c == 97)      applyStimulus(1'b1, 5'd27, 32'd1, (c % 5) < 3);
            else if (c == 98) applyStimulus(1'b1, 5'd3, 32'd33, (c % 5) < 3);
            else if (c == 99) applyStimulus(1'b1, 5'd26, 32'd1, (c % 5) < 3);
            else begin
                rAddr = 5'($urandom_range(0, 31));
                rData = $urandom;
                if (rAddr == 5'd26 && rData == 32'd1) rData = 32'd2;
                applyStimulus($urandom_range(0, 1) == 1, rAddr, rData, (c % 5) < 3);
            end
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd5, 32'd1, 1'b1);
        cmp("perf.pass",    32'(mPass), 32'd1);
        cmp("perf.tnum",    mTnum,      32'd33);
        cmp("perf.cycles",  mCyc,       32'(PERF_ON * 101));
        cmp("perf.retires", mRet,       32'(PERF_ON * 60));
        checkOutput("perf");

        // Random traffic biased towards the snooped registers and the values 0/1/2.
        for (int r = 0; r < 6; r++) begin
            doReset();
            len = (r == 5) ? TMO_CYC_TB + 10 : $urandom_range(20, 60);
            for (int c = 0; c < len; c++) begin
                case ($urandom_range(0, 5))
                    0:       rAddr = 5'd0;
                    1:       rAddr = 5'd3;
                    2:       rAddr = (r == 5) ? 5'd4 : 5'd26;
                    3:       rAddr = 5'd27;
                    default: rAddr = 5'($urandom_range(0, 31));
                endcase
                case ($urandom_range(0, 3))
                    0:       rData = 32'd0;
                    1:       rData = 32'd1;
                    2:       rData = 32'd2;
                    default: rData = $urandom;
                endcase
                applyStimulus($urandom_range(0, 9) < 7, rAddr, rData, $urandom_range(0, 1) == 1);
                checkOutput($sformatf("rand%0d.%0d", r, c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
